// File: rtl/io_tx_arbiter_pkg.sv
// Shared IO definitions: data width, processor port map and the TX arbiter FSM encoding.
package io_tx_arbiter_pkg;

  localparam int          IO_DATA_W       = 8;
  localparam logic [7:0]  UART_TX_PORT    = 8'h01;
  localparam logic [7:0]  RX_PRESENT_PORT = 8'h02;
  localparam logic [7:0]  TX_FULL_PORT    = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/io_tx_arbiter_rr.sv
// Two-requester round-robin grant; bit 0 = processor, bit 1 = debug.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/io_tx_arbiter.sv
// Merges processor IO writes and a debug byte stream onto one UART transmitter,
// one byte per ISSUE/SETTLE round, round-robin on contention.
module io_tx_arbiter
  import io_tx_arbiter_pkg::*;
#(
  parameter int         DATA_W  = IO_DATA_W,
  parameter logic [7:0] TX_PORT = UART_TX_PORT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        io_port_id,
  input  logic [DATA_W-1:0] io_write_data,
  input  logic              io_write_strobe,
  output logic              proc_pending,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_write,
  input  logic              uart_tx_full,
  output logic              last_grant,
  output logic [7:0]        drop_count
);

  tx_state_e         state, state_nxt;
  logic              proc_occ, dbg_occ;
  logic [DATA_W-1:0] proc_q, dbg_q;
  logic [1:0]        gnt, gnt_q;
  logic              proc_hit, start;

  assign proc_hit     = io_write_strobe && (io_port_id == TX_PORT);
  assign start        = (proc_occ || dbg_occ) && !uart_tx_full;
  assign proc_pending = proc_occ;
  assign dbg_ready    = !dbg_occ;

  rr_arbiter2 u_rr (
    .req  ({dbg_occ, proc_occ}),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    uart_write   = 1'b0;
    uart_tx_data = '0;
    if (state == ST_ISSUE) begin
      uart_write   = 1'b1;
      uart_tx_data = gnt_q[1] ? dbg_q : proc_q;
    end
  end

  // A register is cleared only in ISSUE while occupied, and captured only
  // while empty, so capture and clear never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proc_occ   <= 1'b0;
      proc_q     <= '0;
      dbg_occ    <= 1'b0;
      dbg_q      <= '0;
      gnt_q      <= 2'b00;
      last_grant <= 1'b1;
      drop_count <= 8'h00;
    end else begin
      if (state == ST_IDLE && start) gnt_q <= gnt;
      if (state == ST_ISSUE) begin
        if (gnt_q[0]) proc_occ <= 1'b0;
        if (gnt_q[1]) dbg_occ  <= 1'b0;
        last_grant <= gnt_q[1];
      end
      if (proc_hit && !proc_occ) begin
        proc_occ <= 1'b1;
        proc_q   <= io_write_data;
      end else if (proc_hit && proc_occ && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'h01;
      end
      if (dbg_valid && !dbg_occ) begin
        dbg_occ <= 1'b1;
        dbg_q   <= dbg_data;
      end
    end
  end

endmodule

// File: doc/io_tx_arbiter.md
IO_TX_ARBITER -- requirements
Module: io_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of each transmitted byte.
REQ-002 Parameter: TX_PORT, 8'h01, processor IO port ID that addresses the UART transmitter.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 io_port_id  input  8  processor IO port ID.
REQ-006 io_write_data  input  DATA_W  processor write data.
REQ-007 io_write_strobe  input  1  one-cycle processor write strobe.
REQ-008 proc_pending  output  1  processor holding register occupied (readback for the processor).
REQ-009 dbg_data  input  DATA_W  debug/trace byte.
REQ-010 dbg_valid  input  1  debug byte offered.
REQ-011 dbg_ready  output  1  debug holding register free; a transfer occurs when dbg_valid and dbg_ready are both high.
REQ-012 uart_tx_data  output  DATA_W  byte presented to the UART transmitter.
REQ-013 uart_write  output  1  one-cycle UART write pulse.
REQ-014 uart_tx_full  input  1  UART transmit buffer full.
REQ-015 last_grant  output  1  requester served most recently (0 = processor, 1 = debug).
REQ-016 drop_count  output  8  count of processor writes dropped; saturates at 8'hFF.

Function
REQ-017 Processor capture: when io_write_strobe=1, io_port_id=TX_PORT and the processor holding register is empty, the block latches io_write_data and sets proc_pending on the next edge.
REQ-018 A processor write to TX_PORT while proc_pending=1 is dropped: the holding register is unchanged and drop_count increments, saturating at 8'hFF.
REQ-019 Processor strobes addressed to any other port are ignored.
REQ-020 Debug capture: dbg_ready = NOT debug-holding-register-occupied; a handshake latches dbg_data into the debug holding register.
REQ-021 FSM states: IDLE, ISSUE, SETTLE.
REQ-022 IDLE -> ISSUE when at least one holding register is occupied and uart_tx_full=0; the grant is decided in that same cycle.
REQ-023 Grant rule: a single occupied requester wins; when both are occupied, the requester that does not equal last_grant wins (round-robin).
REQ-024 In ISSUE: uart_write=1 for exactly one cycle, uart_tx_data holds the granted byte, the granted register is cleared, last_grant is updated, and the FSM moves to SETTLE.
REQ-025 SETTLE lasts one cycle, covering the UART full-flag latency; the FSM then returns to IDLE. Peak throughput is one byte every 3 cycles.
REQ-026 While uart_tx_full=1, the FSM stays in IDLE and the holding registers keep their contents.
REQ-027 Simultaneous capture and clear of the same register in one cycle is impossible: a register is cleared only in ISSUE, and a new capture is accepted only from the cycle after proc_pending or dbg_ready shows it free.
REQ-028 Latency from processor strobe to uart_write is 2 cycles when the path is idle and uart_tx_full=0.
REQ-029 uart_tx_data is 0 whenever uart_write=0.

Reset
REQ-030 Asserting reset at any time, including during ISSUE, forces: FSM=IDLE, both holding registers empty, proc_pending=0, dbg_ready=1 (from the first edge after reset deassertion), uart_write=0, uart_tx_data=0, last_grant=1 (processor wins the first tie), drop_count=0.
REQ-031 A byte captured but not yet issued when reset asserts is discarded.

Structure
REQ-032 DATA_W, TX_PORT, the FSM state encoding and the UART/status port IDs (8'h01 UART, 8'h02 RX present, 8'h03 TX full) belong in the shared IO package.
REQ-033 The round-robin grant logic is a single sub-module, rr_arbiter2, with inputs req[1:0] and last, output gnt[1:0]; the sub-module is purely combinational.

Verification
REQ-034 Processor write 8'h41 to port 8'h01 with idle path and uart_tx_full=0 -> uart_write pulses 2 cycles later with uart_tx_data=8'h41; proc_pending returns to 0.
REQ-035 Processor 8'h10 and debug 8'h20 captured in the same cycle, last_grant=1 -> 8'h10 issued first, then 8'h20 three cycles later.
REQ-036 Hold uart_tx_full=1 for 10 cycles with both registers occupied -> no uart_write; after release, both bytes are issued in round-robin order.
REQ-037 Three processor writes (8'h01, 8'h02, 8'h03) to TX_PORT on consecutive cycles with uart_tx_full=1 -> only 8'h01 is held, drop_count=2.
REQ-038 Assert reset in the ISSUE cycle -> uart_write drops immediately; after release, all outputs hold their reset values and nothing is transmitted.
REQ-039 Processor write to port 8'h02 -> ignored; proc_pending stays 0, drop_count stays 0.
